// File: rtl/mult_share_arb.sv
// Round-robin front end that time-shares one start/rdy shift-add multiplier
// among NUM_REQ requesters, with a watchdog abort on a missing ready.
module mult_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DP_WIDTH    = 8,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DP_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DP_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          resp_valid,
  output logic [ID_W-1:0]               resp_id,
  output logic [2*DP_WIDTH-1:0]         resp_product,
  output logic                          resp_err,
  output logic                          busy,
  output logic                          mult_start,
  output logic [DP_WIDTH-1:0]           mult_a,
  output logic [DP_WIDTH-1:0]           mult_b,
  input  logic [2*DP_WIDTH-1:0]         mult_product,
  input  logic                          mult_rdy
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [ID_W-1:0]     ptr, gid, win_id;
  logic                win_found, grant, timeout_hit;
  logic [DP_WIDTH-1:0] op_a, op_b, win_a, win_b;
  logic [CNT_W-1:0]    wait_cnt;
  int unsigned         scan_idx;

  assign mult_a      = op_a;
  assign mult_b      = op_b;
  assign grant       = (state == IDLE) && mult_rdy && win_found;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_a     = '0;
    win_b     = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = 32'(ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(scan_idx);
        win_a     = req_a[scan_idx*DP_WIDTH +: DP_WIDTH];
        win_b     = req_b[scan_idx*DP_WIDTH +: DP_WIDTH];
      end
    end
  end

  // Next-state and all handshake/response outputs.
  always_comb begin
    state_nx     = state;
    req_ack      = '0;
    mult_start   = 1'b0;
    resp_valid   = 1'b0;
    resp_id      = '0;
    resp_product = '0;
    resp_err     = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant) begin
          req_ack[win_id] = 1'b1;
          state_nx        = ISSUE;
        end
      end
      ISSUE: begin
        mult_start = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (mult_rdy) begin
          resp_valid   = 1'b1;
          resp_id      = gid;
          resp_product = mult_product;
          state_nx     = IDLE;
        end else if (timeout_hit) begin
          resp_valid = 1'b1;
          resp_id    = gid;
          resp_err   = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, grant bookkeeping, operand capture and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gid      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        op_a <= win_a;
        op_b <= win_b;
        gid  <= win_id;
        ptr  <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
      end
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural start/rdy multiplier.
module tb_mult_share_arb;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int IW  = 2;
  localparam int TO  = 16;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR-1:0]     req_ack;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [2*DW-1:0]   resp_product;
  logic              resp_err;
  logic              busy;
  logic              mult_start;
  logic [DW-1:0]     mult_a, mult_b;
  logic [2*DW-1:0]   mult_product;
  logic              mult_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_share_arb #(.NUM_REQ(NR), .DP_WIDTH(DW), .ID_W(IW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_product(resp_product), .resp_err(resp_err), .busy(busy),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_product(mult_product), .mult_rdy(mult_rdy)
  );

  // Multiplier model: fixed latency after start; m_dead suppresses ready.
  logic            m_rdy, hold_low, m_dead;
  int              m_cnt;
  logic [2*DW-1:0] m_prod;
  assign mult_rdy     = m_rdy & ~hold_low;
  assign mult_product = m_prod;

  always @(posedge clk) begin
    if (rst) begin
      m_rdy  <= 1'b1;
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (mult_start) begin
      m_rdy  <= 1'b0;
      m_cnt  <= LAT;
      m_prod <= {8'b0, mult_a} * {8'b0, mult_b};
    end else if (!m_rdy && !m_dead) begin
      if (m_cnt == 0) m_rdy <= 1'b1;
      else            m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete job: present requests, expect a grant to exp_id, then its result.
  task automatic do_job(input logic [NR-1:0] v, input logic [NR*DW-1:0] a,
                        input logic [NR*DW-1:0] b, input int exp_id,
                        input logic [2*DW-1:0] exp_prod);
    bit seen;
    logic [DW-1:0] ea, eb;
    ea = a[exp_id*DW +: DW];
    eb = b[exp_id*DW +: DW];
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; hold_low = 1'b0;
    #1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ack != '0) begin seen = 1; break; end
      @(negedge clk); #1;
    end
    check("ack_seen", 64'(seen), 64'd1);
    if (!seen) return;
    check("ack_onehot", 64'(req_ack), 64'd1 << exp_id);
    check("busy_idle", 64'(busy), 64'd0);
    @(negedge clk);
    req_valid[exp_id] = 1'b0;
    #1;
    check("start", 64'(mult_start), 64'd1);
    check("ack_pulse", 64'(req_ack), 64'd0);
    check("busy_issue", 64'(busy), 64'd1);
    check("mult_a", 64'(mult_a), 64'(ea));
    check("mult_b", 64'(mult_b), 64'(eb));
    @(negedge clk); #1;
    check("start_pulse", 64'(mult_start), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin seen = 1; break; end
      @(negedge clk); #1;
    end
    check("resp_seen", 64'(seen), 64'd1);
    if (!seen) return;
    check("resp_id", 64'(resp_id), 64'(exp_id));
    check("resp_product", 64'(resp_product), 64'(exp_prod));
    check("resp_err", 64'(resp_err), 64'd0);
    check("mult_a_held", 64'(mult_a), 64'(ea));
  endtask

  typedef struct {
    logic [NR-1:0]    valid;
    logic [NR*DW-1:0] a;
    logic [NR*DW-1:0] b;
    int               exp_id;
    logic [2*DW-1:0]  exp_prod;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [NR*DW-1:0] a_rr, b3;
    bit early, bad;
    a_rr = {8'd4, 8'd3, 8'd2, 8'd1};
    b3   = {8'd3, 8'd3, 8'd3, 8'd3};
    // Rotation 0..3,0; then skip/wrap from ptr=3; then boundary operands.
    tbl[0] = '{4'b1111, a_rr, b3, 0, 16'd3};
    tbl[1] = '{4'b1111, a_rr, b3, 1, 16'd6};
    tbl[2] = '{4'b1111, a_rr, b3, 2, 16'd9};
    tbl[3] = '{4'b1111, a_rr, b3, 3, 16'd12};
    tbl[4] = '{4'b1111, a_rr, b3, 0, 16'd3};
    tbl[5] = '{4'b0100, a_rr, b3, 2, 16'd9};
    tbl[6] = '{4'b0011, a_rr, b3, 0, 16'd3};
    tbl[7] = '{4'b0011, a_rr, b3, 1, 16'd6};
    tbl[8] = '{4'b0100, {8'd4, 8'd13, 8'd2, 8'd1}, {8'd3, 8'd11, 8'd3, 8'd3}, 2, 16'h008F};
    tbl[9] = '{4'b1000, {8'd255, 8'd0, 8'd0, 8'd0}, {8'd255, 8'd0, 8'd0, 8'd0}, 3, 16'hFE01};

    rst = 1'b1; hold_low = 1'b0; m_dead = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_outputs",
          64'({req_ack, resp_valid, resp_id, resp_product, resp_err, busy, mult_start, mult_a, mult_b}),
          64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_after_reset", 64'({busy, req_ack, mult_a}), 64'd0);

    for (int i = 0; i < 10; i++)
      do_job(tbl[i].valid, tbl[i].a, tbl[i].b, tbl[i].exp_id, tbl[i].exp_prod);

    // mult_rdy low in IDLE blocks arbitration.
    @(negedge clk);
    hold_low = 1'b1; req_valid = 4'b0010; req_a = a_rr; req_b = b3;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (req_ack != '0 || mult_start || busy) bad = 1;
      @(negedge clk);
    end
    check("rdy_low_blocks", 64'(bad), 64'd0);
    do_job(4'b0010, a_rr, b3, 1, 16'd6);

    // Watchdog: ready never returns.
    m_dead = 1'b1;
    @(negedge clk);
    req_valid = 4'b0001; req_a = a_rr; req_b = b3;
    #1;
    check("to_ack", 64'(req_ack), 64'd1);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("to_start", 64'(mult_start), 64'd1);
    early = 0;
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk); #1;
      if (n < TO) begin
        if (resp_valid) early = 1;
      end else begin
        check("to_resp_valid", 64'(resp_valid), 64'd1);
        check("to_resp_err", 64'(resp_err), 64'd1);
        check("to_resp_product", 64'(resp_product), 64'd0);
        check("to_resp_id", 64'(resp_id), 64'd0);
      end
    end
    check("to_no_early_resp", 64'(early), 64'd0);
    m_dead = 1'b0;
    do_job(4'b0010, a_rr, b3, 1, 16'd6);

    // Reset during WAIT drops the job and clears the pointer.
    @(negedge clk);
    req_valid = 4'b0100; req_a = a_rr; req_b = b3;
    #1;
    check("rst_job_ack", 64'(req_ack), 64'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp", 64'(resp_valid), 64'd0);
    check("rst_operands", 64'({mult_a, mult_b}), 64'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (resp_valid) bad = 1;
    end
    check("rst_no_resp", 64'(bad), 64'd0);
    do_job(4'b1010, a_rr, b3, 1, 16'd6);
    do_job(4'b1000, a_rr, b3, 3, 16'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
